uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the board UART. Oversamples the asynchronous `uart_rx_pin` line, frames 8N1 characters (optionally 8E1), and delivers each byte as a one-cycle `uart_rx_complete` strobe with `uart_rx_data`. These outputs feed the write side of the hardware-register block's UART receive FIFO, which software reads at E0000014. Framing and parity errors drop the byte and raise their own strobes.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per bit (50 MHz / 115200). Must be ≥ 8.
- `clock`  input  1  system clock; everything runs on the rising edge.
- `reset`  input  1  one clock; reset is asynchronous and active-low (low = in reset).
- `uart_rx_pin`  input  1  asynchronous serial line; idles high.
- `uart_rx_complete`  output  1  one-cycle strobe: `uart_rx_data` holds a new, good byte.
- `uart_rx_data`  output  8  last good byte received; stable between strobes.
- `framing_error`  output  1  one-cycle strobe: stop bit was sampled low.
- `parity_error`  output  1  one-cycle strobe: parity mismatch; tied 0 unless `UART_RX_PARITY_EN`.

## Operation
- **Synchronizer:** two flops on `uart_rx_pin`, both reset to 1. All decisions use the second flop output, `rx_s`.
- **Counters:**
  - Bit-timer `cnt` is wide enough for `CLKS_PER_BIT-1`.
  - `HALF` = `CLKS_PER_BIT/2` (integer division).
  - Bit index `idx` is 3 bits; data is shifted in LSB first.
- **States:**
  - IDLE: `rx_s`=0 → START, `cnt`=0.
  - START: when `cnt`=`HALF-1`, sample `rx_s`. If 0 → DATA, `cnt`=0, `idx`=0. If 1 → IDLE; this is a glitch, with no strobe.
  - DATA: when `cnt`=`CLKS_PER_BIT-1`, shift `rx_s` into the shift register and reset `cnt`. At `idx`=7 → PARITY if enabled, else STOP; otherwise `idx`+1.
  - PARITY (macro only): when `cnt`=`CLKS_PER_BIT-1`, store the sampled parity bit → STOP.
  - STOP: when `cnt`=`CLKS_PER_BIT-1`, sample `rx_s`:
    - 1 with good parity: load `uart_rx_data`, pulse `uart_rx_complete` → IDLE.
    - 1 with bad parity: pulse `parity_error`, leave `uart_rx_data` unchanged → IDLE.
    - 0: pulse `framing_error` → BREAK. Parity is not checked.
  - BREAK: wait for `rx_s`=1 → IDLE. No new start is recognised while the line stays low.
- At most one of the three strobes is high in any cycle.
- **Reset** (any time, including mid-frame):
  - State IDLE; `cnt`, `idx` and shift register 0; synchronizer flops 1.
  - `uart_rx_data`=0x00; all strobes 0.
  - A partial frame is discarded silently.
  - After release, the first falling edge on `rx_s` starts a new frame.

## Timing
- Input latency: 2 cycles from pin to `rx_s`.
- Sampling points, counted from the first cycle `rx_s`=0:
  - Start bit sampled `HALF` cycles later.
  - Data bit n sampled `HALF + (n+1)·CLKS_PER_BIT` cycles later.
  - Stop bit sampled `HALF + 9·CLKS_PER_BIT` cycles later (10 with parity).
- Strobes assert in the cycle after the stop sample and last exactly 1 cycle. `uart_rx_data` changes in that same cycle.
- Back-to-back frames: IDLE is entered half a bit before the stop bit ends, so a start edge immediately after the stop bit is caught. Sustained full-rate traffic gives one strobe per `10·CLKS_PER_BIT` cycles (11 with parity).
- No ready/backpressure: the consumer must accept every strobe.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1, with an even-parity bit between D7 and the stop bit.
  - PARITY state is present; `parity_error` is live.
  - A mismatch drops the byte.
- Undefined:
  - Frame is 8N1; PARITY state is absent.
  - `parity_error` is a constant 0.

## Test plan
All scenarios use `CLKS_PER_BIT`=16, with the line driven at exactly 16 cycles per bit.
- **Single byte:** send 0xA5 8N1 → exactly one `uart_rx_complete`, `uart_rx_data`=0xA5. Strobe at start edge + 2 + 8 + 144 + 1 cycles. No error strobes.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap → two strobes 160 cycles apart, data 0x00 then 0xFF.
- **Glitch:** pulse the line low for 4 cycles → no strobe; state returns to IDLE. A following 0x3C is received correctly.
- **Framing error:**
  - Send 0x5A with the stop bit low, then hold the line low for 48 cycles → one `framing_error`, no `uart_rx_complete`, `uart_rx_data` unchanged.
  - Release the line, then send 0x3C → complete strobe with data 0x3C.
- **Reset mid-frame:**
  - Assert reset low for 3 cycles during data bit 4 of 0x81 → outputs reset to 0 immediately (asynchronously), no strobe for that frame.
  - Release, then send 0x42 → data 0x42.
- **With `UART_RX_PARITY_EN`:**
  - Send 0x07 with parity 1 → complete, data 0x07.
  - Send 0x07 with parity 0 → one `parity_error`, no complete, data stays 0x07.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver; define UART_RX_PARITY_EN for 8E1 with a live parity_error.
// Each frame ends in exactly one strobe: uart_rx_complete, framing_error or parity_error (never backpressured).
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx_pin,
  output logic       uart_rx_complete,
  output logic [7:0] uart_rx_data,
  output logic       framing_error,
  output logic       parity_error
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] HALF_M1 = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif
  logic [1:0]   r_sync;
  logic [2:0]   r_state;
  logic [W-1:0] r_cnt;
  logic [2:0]   r_idx;
  logic [7:0]   r_shift;
  logic         w_rx;
  logic         w_tick;
  logic         w_par_ok;
  assign w_rx = r_sync[1];
  assign w_tick = r_cnt == LAST;
`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic r_perr;
  // Even parity: data plus parity bit must hold an even number of ones.
  assign w_par_ok = ~^{r_shift, r_par};
  assign parity_error = r_perr;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_perr <= r_state == S_STOP && w_tick && w_rx && !w_par_ok;
      if (r_state == S_PARITY && w_tick) r_par <= w_rx;
    end
  end
`else
  assign w_par_ok = 1'b1;
  assign parity_error = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync           <= 2'b11;
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_idx            <= '0;
      r_shift          <= '0;
      uart_rx_data     <= '0;
      uart_rx_complete <= 1'b0;
      framing_error    <= 1'b0;
    end else begin
      r_sync           <= {r_sync[0], uart_rx_pin};
      uart_rx_complete <= 1'b0;
      framing_error    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx) r_state <= S_START;
        end
        S_START: begin
          r_cnt <= r_cnt == HALF_M1 ? '0 : r_cnt + W'(1);
          r_idx <= '0;
          // A start bit that is high again at mid-bit was a glitch.
          if (r_cnt == HALF_M1) r_state <= w_rx ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          r_cnt <= w_tick ? '0 : r_cnt + W'(1);
          if (w_tick) begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_AFTER_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          r_cnt <= w_tick ? '0 : r_cnt + W'(1);
          if (w_tick) r_state <= S_STOP;
        end
`endif
        S_STOP: begin
          r_cnt <= w_tick ? '0 : r_cnt + W'(1);
          if (w_tick) begin
            r_state          <= w_rx ? S_IDLE : S_BREAK;
            framing_error    <= !w_rx;
            uart_rx_complete <= w_rx && w_par_ok;
            if (w_rx && w_par_ok) uart_rx_data <= r_shift;
          end
        end
        S_BREAK: begin
          r_cnt <= '0;
          if (w_rx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level model of the receiver.
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NB = 10;
  localparam bit PAR_EN = 1'b0;
`endif
  // Pin-to-strobe: 2 sync, half a bit to the start sample, NB-1 bits to the stop sample.
  localparam int LAT = 2 + CPB / 2 + (NB - 1) * CPB;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic uart_rx_pin = 1'b1;
  logic uart_rx_complete;
  logic framing_error;
  logic parity_error;
  logic [7:0] uart_rx_data;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_done = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_multi = 0;
  int done_cyc = 0;
  int prev_cyc = 0;
  int t_start = 0;
  logic [7:0] got_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock),
    .reset(reset),
    .uart_rx_pin(uart_rx_pin),
    .uart_rx_complete(uart_rx_complete),
    .uart_rx_data(uart_rx_data),
    .framing_error(framing_error),
    .parity_error(parity_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (uart_rx_complete) begin
      n_done   <= n_done + 1;
      prev_cyc <= done_cyc;
      done_cyc <= cyc;
      got_q.push_back(uart_rx_data);
    end
    if (framing_error) n_ferr <= n_ferr + 1;
    if (parity_error) n_perr <= n_perr + 1;
    if (int'(uart_rx_complete) + int'(framing_error) + int'(parity_error) > 1) n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Frame bits LSB first: start, D0..D7, [even parity, inverted when bad], stop.
  task automatic send(input logic [7:0] b, input logic stop, input logic bad);
    logic [10:0] f;
    logic p;
    p = ^b ^ bad;
`ifdef UART_RX_PARITY_EN
    f = {stop, p, b, 1'b0};
`else
    f = {p, stop, b, 1'b0};
`endif
    t_start = cyc + 1;
    for (int i = 0; i < NB; i++) begin
      uart_rx_pin = f[i];
      wait_n(CPB);
    end
  endtask

  function automatic logic [7:0] pop_rx();
    return got_q.size() > 0 ? got_q.pop_front() : 8'hxx;
  endfunction

  initial begin
    int d0, f0, p0;
    logic [7:0] b, m_data;
    logic stop, bad;
    wait_n(4);
    #1;
    chk("rst_data", 32'(uart_rx_data), 0);
    chk("rst_complete", 32'(uart_rx_complete), 0);
    chk("rst_ferr", 32'(framing_error), 0);
    chk("rst_perr", 32'(parity_error), 0);
    reset = 1'b1;
    wait_n(20);

    d0 = n_done; f0 = n_ferr; p0 = n_perr;
    send(8'hA5, 1'b1, 1'b0);
    #1;
    chk("a5_count", n_done - d0, 1);
    chk("a5_data", 32'(uart_rx_data), 32'hA5);
    chk("a5_latency", done_cyc - t_start, LAT);
    chk("a5_errors", n_ferr + n_perr - f0 - p0, 0);

    uart_rx_pin = 1'b1;
    wait_n(10);
    got_q.delete();
    d0 = n_done;
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    #1;
    chk("b2b_count", n_done - d0, 2);
    chk("b2b_first", 32'(pop_rx()), 32'h00);
    chk("b2b_second", 32'(pop_rx()), 32'hFF);
    chk("b2b_spacing", done_cyc - prev_cyc, NB * CPB);

    uart_rx_pin = 1'b1;
    wait_n(20);
    d0 = n_done; f0 = n_ferr; p0 = n_perr;
    uart_rx_pin = 1'b0;
    wait_n(4);
    uart_rx_pin = 1'b1;
    wait_n(40);
    #1;
    chk("glitch_no_strobe", n_done + n_ferr + n_perr - d0 - f0 - p0, 0);
    send(8'h3C, 1'b1, 1'b0);
    #1;
    chk("glitch_next_count", n_done - d0, 1);
    chk("glitch_next_data", 32'(uart_rx_data), 32'h3C);

    uart_rx_pin = 1'b1;
    wait_n(20);
    d0 = n_done; f0 = n_ferr;
    send(8'h5A, 1'b0, 1'b0);
    wait_n(48);
    #1;
    chk("frame_ferr", n_ferr - f0, 1);
    chk("frame_no_done", n_done - d0, 0);
    chk("frame_data_kept", 32'(uart_rx_data), 32'h3C);
    uart_rx_pin = 1'b1;
    wait_n(20);
    send(8'h3C, 1'b1, 1'b0);
    #1;
    chk("frame_recover_count", n_done - d0, 1);
    chk("frame_recover_data", 32'(uart_rx_data), 32'h3C);

    uart_rx_pin = 1'b1;
    wait_n(20);
    d0 = n_done; f0 = n_ferr; p0 = n_perr;
    b = 8'h81;
    uart_rx_pin = 1'b0;
    wait_n(CPB);
    for (int i = 0; i < 4; i++) begin
      uart_rx_pin = b[i];
      wait_n(CPB);
    end
    uart_rx_pin = b[4];
    wait_n(5);
    #2 reset = 1'b0;
    #1;
    chk("midrst_data", 32'(uart_rx_data), 0);
    chk("midrst_complete", 32'(uart_rx_complete), 0);
    uart_rx_pin = 1'b1;
    wait_n(3);
    reset = 1'b1;
    wait_n(200);
    #1;
    chk("midrst_no_strobe", n_done + n_ferr + n_perr - d0 - f0 - p0, 0);
    send(8'h42, 1'b1, 1'b0);
    #1;
    chk("midrst_next_count", n_done - d0, 1);
    chk("midrst_next_data", 32'(uart_rx_data), 32'h42);
    m_data = 8'h42;

`ifdef UART_RX_PARITY_EN
    uart_rx_pin = 1'b1;
    wait_n(20);
    d0 = n_done; p0 = n_perr;
    send(8'h07, 1'b1, 1'b0);
    #1;
    chk("par_good_count", n_done - d0, 1);
    chk("par_good_data", 32'(uart_rx_data), 32'h07);
    uart_rx_pin = 1'b1;
    wait_n(20);
    send(8'h07, 1'b1, 1'b1);
    #1;
    chk("par_bad_perr", n_perr - p0, 1);
    chk("par_bad_no_done", n_done - d0, 1);
    chk("par_bad_data", 32'(uart_rx_data), 32'h07);
    m_data = 8'h07;
`else
    chk("no_parity_strobe", n_perr, 0);
`endif

    uart_rx_pin = 1'b1;
    wait_n(20);
    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom);
      stop = $urandom_range(0, 7) != 0;
      bad = PAR_EN && ($urandom_range(0, 3) == 0);
      d0 = n_done; f0 = n_ferr; p0 = n_perr;
      send(b, stop, bad);
      #1;
      if (stop && !bad) m_data = b;
      chk("rnd_done", n_done - d0, (stop && !bad) ? 1 : 0);
      chk("rnd_ferr", n_ferr - f0, stop ? 0 : 1);
      chk("rnd_perr", n_perr - p0, (stop && bad) ? 1 : 0);
      chk("rnd_data", 32'(uart_rx_data), 32'(m_data));
      uart_rx_pin = 1'b1;
      wait_n(stop ? $urandom_range(0, 12) : $urandom_range(3, 20));
    end

    chk("one_strobe_max", n_multi, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
